// File: rtl/tpu_pkg.sv
// Shared types and score-ordering helper for the argmax scanner.
// score_key maps a raw score onto an unsigned key where a larger key means a better score.
package tpu_pkg;

    localparam int unsigned MODE_SIGNMAG = 32'd0;
    localparam int unsigned MODE_TWOS    = 32'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Key is width+1 bits in the low end of the result; scores up to 32 bits are supported.
    function automatic logic [32:0] score_key(
        input logic [31:0] v,
        input int unsigned width,
        input int unsigned mode
    );
        logic [32:0] top_bit;
        logic [32:0] mag_mask;
        logic [32:0] mag;
        logic [32:0] key;
        top_bit  = 33'd1 << (width - 32'd1);
        mag_mask = top_bit - 33'd1;
        mag      = {1'b0, v} & mag_mask;
        if (mode == MODE_TWOS) begin
            key = ({1'b0, v} ^ top_bit) & (mag_mask | top_bit);
        end else if (({1'b0, v} & top_bit) == 33'd0) begin
            key = (top_bit << 1) | mag;
        end else if (mag == 33'd0) begin
            // negative zero is the saturation marker and outranks every value
            key = (top_bit << 1) | top_bit;
        end else begin
            key = top_bit | (~mag & mag_mask);
        end
        return key;
    endfunction

endpackage

// File: rtl/argmax_key_enc.sv
// Combinational score-to-key encoder; one instance per compare lane plus the running max.
module argmax_key_enc
    import tpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic [WIDTH-1:0] score,
    output logic [WIDTH:0]   key
);

    assign key = (WIDTH + 1)'(score_key(32'(score), WIDTH, MODE));

endmodule

// File: rtl/argmax_seq.sv
// Sequential argmax over a packed score vector, LANES slices per scan cycle,
// with valid/ready handshakes on the input vector and the held result.
module argmax_seq
    import tpu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int N_CLASS     = 10,
    parameter int LANES       = 1,
    parameter int MODE        = 0,
    parameter int REVERSE_IDX = 1,
    localparam int IDX_W      = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_CLASS*WIDTH-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_max,
    output logic [IDX_W-1:0]           out_index,
    output logic                       busy
);

    localparam int PTR_W = $clog2(N_CLASS + LANES + 1);
    localparam int KEY_W = WIDTH + 1;

    state_t                     state_r;
    state_t                     state_s;
    logic [N_CLASS*WIDTH-1:0]   vec_r;
    logic [WIDTH-1:0]           max_r;
    logic [IDX_W-1:0]           pos_r;
    logic [PTR_W-1:0]           ptr_r;
    logic [WIDTH-1:0]           out_max_r;
    logic [IDX_W-1:0]           out_index_r;

    logic [WIDTH-1:0]           lane_score_s [LANES];
    logic [KEY_W-1:0]           lane_key_s   [LANES];
    logic                       lane_ok_s    [LANES];
    logic [KEY_W-1:0]           max_key_s;
    logic [WIDTH-1:0]           best_val_s;
    logic [IDX_W-1:0]           best_pos_s;
    logic [KEY_W-1:0]           best_key_s;
    logic                       last_s;

    function automatic logic [IDX_W-1:0] map_index(input logic [IDX_W-1:0] pos);
        if (REVERSE_IDX != 0) begin
            return IDX_W'(N_CLASS - 1) - pos;
        end else begin
            return pos;
        end
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [PTR_W-1:0] idx_s;
        logic [PTR_W-1:0] idx_c_s;
        assign idx_s            = ptr_r + PTR_W'(l);
        assign lane_ok_s[l]     = (idx_s < PTR_W'(N_CLASS));
        assign idx_c_s          = lane_ok_s[l] ? idx_s : PTR_W'(0);
        assign lane_score_s[l]  = WIDTH'(vec_r >> (32'(idx_c_s) * WIDTH));

        argmax_key_enc #(.WIDTH(WIDTH), .MODE(MODE)) u_enc (
            .score (lane_score_s[l]),
            .key   (lane_key_s[l])
        );
    end

    argmax_key_enc #(.WIDTH(WIDTH), .MODE(MODE)) u_enc_max (
        .score (max_r),
        .key   (max_key_s)
    );

    assign last_s    = ((ptr_r + PTR_W'(LANES)) >= PTR_W'(N_CLASS));
    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = (state_r == DONE);
    assign out_max   = out_max_r;
    assign out_index = out_index_r;

    // Compare chain: lanes in ascending position, strict greater keeps the lowest position on ties
    always_comb begin
        best_val_s = max_r;
        best_pos_s = pos_r;
        best_key_s = max_key_s;
        for (int l = 0; l < LANES; l++) begin
            if (lane_ok_s[l] && (lane_key_s[l] > best_key_s)) begin
                best_val_s = lane_score_s[l];
                best_pos_s = IDX_W'(ptr_r + PTR_W'(l));
                best_key_s = lane_key_s[l];
            end else begin
                best_val_s = best_val_s;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = (N_CLASS == 1) ? DONE : SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SCAN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Vector capture, running max/pointer, and result registers loaded on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_r       <= '0;
            max_r       <= '0;
            pos_r       <= '0;
            ptr_r       <= '0;
            out_max_r   <= '0;
            out_index_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        vec_r <= in_data;
                        max_r <= in_data[WIDTH-1:0];
                        pos_r <= '0;
                        ptr_r <= PTR_W'(1);
                        if (N_CLASS == 1) begin
                            out_max_r   <= in_data[WIDTH-1:0];
                            out_index_r <= map_index('0);
                        end
                    end
                end
                SCAN: begin
                    max_r <= best_val_s;
                    pos_r <= best_pos_s;
                    ptr_r <= ptr_r + PTR_W'(LANES);
                    if (last_s) begin
                        out_max_r   <= best_val_s;
                        out_index_r <= map_index(best_pos_s);
                    end
                end
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_seq.sv
// Self-checking bench: three argmax_seq configurations (MODE0/L1, MODE1/L1, MODE0/L3)
// driven from a shared stimulus task with a scoreboard of expected results.
module tb_argmax_seq;

    logic        clk;
    logic        rst;
    logic [79:0] in_data;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  ov;
    logic [2:0]  ir;
    logic [2:0]  bz;
    logic [7:0]  om [3];
    logic [3:0]  oi [3];

    int total;
    int bad;
    logic [11:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    argmax_seq #(.WIDTH(8), .N_CLASS(10), .LANES(1), .MODE(0), .REVERSE_IDX(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_max(om[0]), .out_index(oi[0]), .busy(bz[0]));

    argmax_seq #(.WIDTH(8), .N_CLASS(10), .LANES(1), .MODE(1), .REVERSE_IDX(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_max(om[1]), .out_index(oi[1]), .busy(bz[1]));

    argmax_seq #(.WIDTH(8), .N_CLASS(10), .LANES(3), .MODE(0), .REVERSE_IDX(1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_max(om[2]), .out_index(oi[2]), .busy(bz[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sval(input logic [7:0] s, input int mode);
        if (mode == 1) return int'($signed(s));
        else if (s == 8'h80) return 1000;
        else if (s[7]) return -int'(s[6:0]);
        else return int'(s[6:0]);
    endfunction

    function automatic logic [11:0] model(input logic [79:0] v, input int mode);
        int best;
        int bp;
        int x;
        best = sval(v[7:0], mode);
        bp   = 0;
        for (int p = 1; p < 10; p++) begin
            x = sval(v[p*8 +: 8], mode);
            if (x > best) begin
                best = x;
                bp   = p;
            end
        end
        return {v[bp*8 +: 8], 4'(9 - bp)};
    endfunction

    task automatic wait_ready(input int sel);
        int n;
        n = 0;
        while (!ir[sel] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("in_ready_idle", 32'(ir[sel]), 32'd1);
    endtask

    task automatic run_vec(input int sel, input logic [79:0] v, input logic [11:0] exp, input int stall);
        int n;
        int lat_exp;
        logic [11:0] e;
        lat_exp = (sel == 2) ? 3 : 9;
        wait_ready(sel);
        @(negedge clk);
        in_data = v;
        iv[sel] = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        check_val("busy_after_accept", 32'(bz[sel]), 32'd1);
        check_val("in_ready_busy", 32'(ir[sel]), 32'd0);
        n = 0;
        while (!ov[sel] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("latency", n, lat_exp);
        e = sb.pop_front();
        check_val("out_max", 32'(om[sel]), 32'(e[11:4]));
        check_val("out_index", 32'(oi[sel]), 32'(e[3:0]));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check_val("stall_valid", 32'(ov[sel]), 32'd1);
            check_val("stall_in_ready", 32'(ir[sel]), 32'd0);
            check_val("stall_max", 32'(om[sel]), 32'(e[11:4]));
            check_val("stall_index", 32'(oi[sel]), 32'(e[3:0]));
        end
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        check_val("valid_drop", 32'(ov[sel]), 32'd0);
        check_val("in_ready_rise", 32'(ir[sel]), 32'd1);
    endtask

    localparam logic [79:0] V_T1   = 80'h7E84_1122_0001_7F10_8305;
    localparam logic [79:0] V_SAT  = 80'h7E84_8022_0001_7F10_8305;
    localparam logic [79:0] V_NEG  = 80'h8A89_8887_8681_8283_8485;
    localparam logic [79:0] V_TIE  = 80'h1010_1040_1010_1040_1010;
    localparam logic [79:0] V_M1A  = 80'hFF00_FFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] V_M1B  = 80'hFEFE_FEFE_FEFE_FEFE_FE80;

    initial begin
        logic [79:0] v;
        logic [7:0]  pick [8];
        int          mode;
        total   = 0;
        bad     = 0;
        in_data = '0;
        iv      = '0;
        ordy    = '0;
        rst     = 1'b1;
        pick    = '{8'h80, 8'h7F, 8'h00, 8'h81, 8'hFF, 8'h40, 8'h01, 8'hC0};
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(ov[0]), 32'd0);
        check_val("rst_busy", 32'(bz[0]), 32'd0);
        check_val("rst_max", 32'(om[0]), 32'd0);
        check_val("rst_index", 32'(oi[0]), 32'd0);
        check_val("rst_in_ready", 32'(ir[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        run_vec(0, V_T1,  {8'h7F, 4'd6}, 0);
        run_vec(0, V_SAT, {8'h80, 4'd2}, 0);
        run_vec(0, {10{8'h80}}, {8'h80, 4'd9}, 0);
        run_vec(0, V_NEG, {8'h81, 4'd5}, 0);
        run_vec(0, V_TIE, {8'h40, 4'd7}, 0);
        run_vec(1, V_M1A, {8'h00, 4'd1}, 0);
        run_vec(1, V_M1B, {8'hFE, 4'd8}, 0);
        run_vec(2, V_T1,  {8'h7F, 4'd6}, 5);
        run_vec(2, V_TIE, {8'h40, 4'd7}, 0);
        run_vec(2, V_SAT, {8'h80, 4'd2}, 0);

        // randomised vectors from a small value set to provoke ties and the 0x80 code
        for (int r = 0; r < 6; r++) begin
            for (int sel = 0; sel < 3; sel++) begin
                for (int p = 0; p < 10; p++) v[p*8 +: 8] = pick[$urandom_range(7, 0)];
                mode = (sel == 1) ? 1 : 0;
                run_vec(sel, v, model(v, mode), r % 2);
            end
        end

        // abort a scan on dut0 once ptr has reached 4; last dut0 result has a non-zero index
        run_vec(0, V_NEG, {8'h81, 4'd5}, 0);
        wait_ready(0);
        @(negedge clk);
        in_data = V_SAT;
        iv[0]   = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("abort_valid", 32'(ov[0]), 32'd0);
        check_val("abort_index", 32'(oi[0]), 32'd0);
        check_val("abort_busy", 32'(bz[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("abort_in_ready", 32'(ir[0]), 32'd1);
        run_vec(0, V_T1, {8'h7F, 4'd6}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
